sequenciador_ula: RTL and testbench

- Multi-cycle fetch/execute sequencer for the 4-bit X/Y/Z + soma datapath.
- Replaces the free-running contador + combinational controle pair. Owns the program counter and addresses memoria.
- Decodes each {func, val} word into one-cycle register/ALU control strobes.
- Adds jumps, a zero-test branch, a hardware loop counter and halt.

---
 rtl/sequenciador_ula.sv | 165 ++++++++++++++++
 tb/tb_sequenciador_ula.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_ula.sv
// Fetch/execute sequencer for the X/Y/Z + soma datapath: owns the PC, decodes {func, val} into one-cycle strobes.
// Optional single-step gating of FETCH->EXEC is enabled with the SEQ_STEP_EN macro.
module sequenciador_ula #(
    parameter int unsigned PC_W     = 4,
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef SEQ_STEP_EN
    input  logic              step,
`endif
    input  logic [3:0]        mem_func,
    input  logic [DATA_W-1:0] mem_val,
    input  logic              y_zero,
    output logic [PC_W-1:0]   pc,
    output logic [1:0]        auxX,
    output logic [2:0]        auxY,
    output logic [1:0]        auxZ,
    output logic              auxULA,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } stateT;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDX  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_MOVZ = 4'h4,
        OP_CLRX = 4'h5,
        OP_CLRY = 4'h6,
        OP_SHRY = 4'h7,
        OP_SHLY = 4'h8,
        OP_JMP  = 4'h9,
        OP_JZ   = 4'hA,
        OP_LOOP = 4'hB,
        OP_DJNZ = 4'hC,
        OP_HALT = 4'hF
    } opcodeT;

    localparam logic [PC_W-1:0] PC_START = PC_W'(RESET_PC);

    stateT             state, stateNext;
    logic [PC_W-1:0]   pcNext;
    logic [3:0]        instrFunc, funcNext;
    logic [DATA_W-1:0] instrVal, valNext;
    logic [DATA_W-1:0] loopCnt, loopNext;
    logic [PC_W-1:0]   pcInc;
    logic [PC_W-1:0]   jumpTarget;
    logic [DATA_W-1:0] loopDec;
    logic              fetchGo;

    // Jump targets are zero-extended or truncated to the address width.
    generate
        if (PC_W > DATA_W) begin : gTargetExt
            assign jumpTarget = {{(PC_W-DATA_W){1'b0}}, instrVal};
        end else begin : gTargetTrunc
            assign jumpTarget = instrVal[PC_W-1:0];
        end
    endgenerate

    assign pcInc   = pc + PC_W'(1);
    assign loopDec = loopCnt - DATA_W'(1);

`ifdef SEQ_STEP_EN
    assign fetchGo = step;
`else
    assign fetchGo = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= PC_START;
            instrFunc <= '0;
            instrVal  <= '0;
            loopCnt   <= '0;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            instrFunc <= funcNext;
            instrVal  <= valNext;
            loopCnt   <= loopNext;
        end
    end

    always_comb begin
        stateNext = state;
        pcNext    = pc;
        funcNext  = instrFunc;
        valNext   = instrVal;
        loopNext  = loopCnt;
        auxX      = '0;
        auxY      = '0;
        auxZ      = '0;
        auxULA    = 1'b0;
        busy      = (state == FETCH) || (state == EXEC);
        halted    = (state == HALT);

        unique case (state)
            IDLE, HALT: begin
                if (start) begin
                    stateNext = FETCH;
                    pcNext    = PC_START;
                    loopNext  = '0;
                end
            end

            FETCH: begin
                if (fetchGo) begin
                    funcNext  = mem_func;
                    valNext   = mem_val;
                    stateNext = EXEC;
                end
            end

            EXEC: begin
                stateNext = FETCH;
                pcNext    = pcInc;
                case (instrFunc)
                    OP_LDX:  auxX = 2'b01;
                    OP_ADD:  auxY = 3'b001;
                    OP_SUB: begin
                        auxY   = 3'b001;
                        auxULA = 1'b1;
                    end
                    OP_MOVZ: auxZ = 2'b01;
                    OP_CLRX: auxX = 2'b10;
                    OP_CLRY: auxY = 3'b010;
                    OP_SHRY: auxY = 3'b011;
                    OP_SHLY: auxY = 3'b100;
                    OP_JMP:  pcNext = jumpTarget;
                    OP_JZ: begin
                        if (y_zero) pcNext = jumpTarget;
                    end
                    OP_LOOP: loopNext = instrVal;
                    // An exhausted counter falls through without wrapping to all-ones.
                    OP_DJNZ: begin
                        if (loopCnt != '0) begin
                            loopNext = loopDec;
                            if (loopDec != '0) pcNext = jumpTarget;
                        end
                    end
                    OP_HALT: begin
                        pcNext    = pc;
                        stateNext = HALT;
                    end
                    default: ;
                endcase
            end

            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sequenciador_ula.sv
// Directed bench for sequenciador_ula: expected output vectors are queued per program and checked cycle by cycle.
module tb_sequenciador_ula;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       step = 1'b0;
    logic [3:0] mem_func;
    logic [3:0] mem_val;
    logic       y_zero = 1'b0;
    logic [3:0] pc;
    logic [1:0] auxX;
    logic [2:0] auxY;
    logic [1:0] auxZ;
    logic       auxULA;
    logic       busy;
    logic       halted;

    logic [7:0] prog [16];

    typedef struct {
        string       tag;
        logic [13:0] exp;
    } expT;

    expT expQ[$];
    int  compared = 0;
    int  mismatched = 0;

    always #5 clk = ~clk;

    assign mem_func = prog[pc][7:4];
    assign mem_val  = prog[pc][3:0];

    sequenciador_ula #(.PC_W(4), .DATA_W(4), .RESET_PC(0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
`ifdef SEQ_STEP_EN
        .step(step),
`endif
        .mem_func(mem_func),
        .mem_val(mem_val),
        .y_zero(y_zero),
        .pc(pc),
        .auxX(auxX),
        .auxY(auxY),
        .auxZ(auxZ),
        .auxULA(auxULA),
        .busy(busy),
        .halted(halted)
    );

    function automatic logic [13:0] mk(input logic [3:0] p, input logic [1:0] x, input logic [2:0] y,
                                       input logic [1:0] z, input logic u, input logic b, input logic h);
        return {p, x, y, z, u, b, h};
    endfunction

    function automatic logic [13:0] fe(input logic [3:0] p);
        return mk(p, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1, 1'b0);
    endfunction

    function automatic logic [13:0] ex(input logic [3:0] p, input logic [1:0] x, input logic [2:0] y,
                                       input logic [1:0] z, input logic u);
        return mk(p, x, y, z, u, 1'b1, 1'b0);
    endfunction

    function automatic logic [13:0] ha(input logic [3:0] p);
        return mk(p, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1);
    endfunction

    task automatic push(input string tag, input logic [13:0] e);
        expT item;
        item.tag = tag;
        item.exp = e;
        expQ.push_back(item);
    endtask

    task automatic compareFront();
        expT         item;
        logic [13:0] obs;
        compared++;
        if (expQ.size() == 0) begin
            mismatched++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            item = expQ.pop_front();
            obs  = {pc, auxX, auxY, auxZ, auxULA, busy, halted};
            assert (obs === item.exp)
            else begin
                mismatched++;
                $error("FAIL %s observed={pc=%h x=%b y=%b z=%b ula=%b busy=%b halt=%b} expected={pc=%h x=%b y=%b z=%b ula=%b busy=%b halt=%b}",
                       item.tag, obs[13:10], obs[9:8], obs[7:5], obs[4:3], obs[2], obs[1], obs[0],
                       item.exp[13:10], item.exp[9:8], item.exp[7:5], item.exp[4:3], item.exp[2],
                       item.exp[1], item.exp[0]);
            end
        end
    endtask

    task automatic runExpect(input logic holdStart);
        int n;
        n = expQ.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!holdStart) start = 1'b0;
            compareFront();
        end
    endtask

    task automatic clearProg();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    endtask

    initial begin
        clearProg();

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1;
        push("reset_async", mk(4'd0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0));
        compareFront();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // LDX 3; ADD; MOVZ; HALT
        prog[0] = 8'h13; prog[1] = 8'h20; prog[2] = 8'h40; prog[3] = 8'hF0;
        push("p1_fetch0", fe(4'd0));
        push("p1_ldx",    ex(4'd0, 2'b01, 3'b000, 2'b00, 1'b0));
        push("p1_fetch1", fe(4'd1));
        push("p1_add",    ex(4'd1, 2'b00, 3'b001, 2'b00, 1'b0));
        push("p1_fetch2", fe(4'd2));
        push("p1_movz",   ex(4'd2, 2'b00, 3'b000, 2'b01, 1'b0));
        push("p1_fetch3", fe(4'd3));
        push("p1_halt_exec", ex(4'd3, 2'b00, 3'b000, 2'b00, 1'b0));
        push("p1_halted", ha(4'd3));
        push("p1_halt_hold", ha(4'd3));
        start = 1'b1;
        runExpect(1'b0);

        // JZ 7 at address 2, taken
        clearProg();
        prog[0] = 8'h00; prog[1] = 8'h30; prog[2] = 8'hA7; prog[3] = 8'hF0; prog[7] = 8'hF0;
        y_zero = 1'b1;
        push("jz1_fetch0", fe(4'd0));
        push("jz1_exec0",  ex(4'd0, 2'b00, 3'b000, 2'b00, 1'b0));
        push("jz1_fetch1", fe(4'd1));
        push("jz1_sub",    ex(4'd1, 2'b00, 3'b001, 2'b00, 1'b1));
        push("jz1_fetch2", fe(4'd2));
        push("jz1_exec2",  ex(4'd2, 2'b00, 3'b000, 2'b00, 1'b0));
        push("jz1_target", fe(4'd7));
        push("jz1_exec7",  ex(4'd7, 2'b00, 3'b000, 2'b00, 1'b0));
        push("jz1_halted", ha(4'd7));
        start = 1'b1;
        runExpect(1'b0);

        // Same program, not taken
        y_zero = 1'b0;
        push("jz0_fetch0", fe(4'd0));
        push("jz0_exec0",  ex(4'd0, 2'b00, 3'b000, 2'b00, 1'b0));
        push("jz0_fetch1", fe(4'd1));
        push("jz0_sub",    ex(4'd1, 2'b00, 3'b001, 2'b00, 1'b1));
        push("jz0_fetch2", fe(4'd2));
        push("jz0_exec2",  ex(4'd2, 2'b00, 3'b000, 2'b00, 1'b0));
        push("jz0_fallthru", fe(4'd3));
        push("jz0_exec3",  ex(4'd3, 2'b00, 3'b000, 2'b00, 1'b0));
        push("jz0_halted", ha(4'd3));
        start = 1'b1;
        runExpect(1'b0);

        // LOOP 3; ADD; DJNZ 1; DJNZ 6 (counter exhausted -> fall through); HALT
        clearProg();
        prog[0] = 8'hB3; prog[1] = 8'h20; prog[2] = 8'hC1; prog[3] = 8'hC6;
        prog[4] = 8'hF0; prog[6] = 8'hF0;
        push("lp_fetch0", fe(4'd0));
        push("lp_loop",   ex(4'd0, 2'b00, 3'b000, 2'b00, 1'b0));
        for (int k = 0; k < 3; k++) begin
            push($sformatf("lp_fetch_add%0d", k), fe(4'd1));
            push($sformatf("lp_add%0d", k), ex(4'd1, 2'b00, 3'b001, 2'b00, 1'b0));
            push($sformatf("lp_fetch_djnz%0d", k), fe(4'd2));
            push($sformatf("lp_djnz%0d", k), ex(4'd2, 2'b00, 3'b000, 2'b00, 1'b0));
        end
        push("lp_fallthru3", fe(4'd3));
        push("lp_djnz_zero", ex(4'd3, 2'b00, 3'b000, 2'b00, 1'b0));
        push("lp_fallthru4", fe(4'd4));
        push("lp_exec4",     ex(4'd4, 2'b00, 3'b000, 2'b00, 1'b0));
        push("lp_halted",    ha(4'd4));
        start = 1'b1;
        runExpect(1'b0);

        // JMP 14; NOP at 14; ADD at 15 -> wraps to 0 without halting
        clearProg();
        prog[0] = 8'h9E; prog[14] = 8'h00; prog[15] = 8'h20;
        push("wr_fetch0",  fe(4'd0));
        push("wr_jmp",     ex(4'd0, 2'b00, 3'b000, 2'b00, 1'b0));
        push("wr_fetch14", fe(4'd14));
        push("wr_exec14",  ex(4'd14, 2'b00, 3'b000, 2'b00, 1'b0));
        push("wr_fetch15", fe(4'd15));
        push("wr_exec15",  ex(4'd15, 2'b00, 3'b001, 2'b00, 1'b0));
        push("wr_wrap0",   fe(4'd0));
        push("wr_jmp2",    ex(4'd0, 2'b00, 3'b000, 2'b00, 1'b0));
        push("wr_fetch14b", fe(4'd14));
        start = 1'b1;
        runExpect(1'b0);

        // start held while busy must not restart
        push("busy_exec14", ex(4'd14, 2'b00, 3'b000, 2'b00, 1'b0));
        push("busy_fetch15", fe(4'd15));
        push("busy_exec15", ex(4'd15, 2'b00, 3'b001, 2'b00, 1'b0));
        start = 1'b1;
        runExpect(1'b1);
        start = 1'b0;

        // Reset in the middle of an EXEC strobe clears outputs without a clock edge
        #1 rst_n = 1'b0;
        #1;
        push("reset_mid_exec", mk(4'd0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0));
        compareFront();
        #1 rst_n = 1'b1;
        push("idle_after_reset", mk(4'd0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0));
        runExpect(1'b0);

`ifdef SEQ_STEP_EN
        clearProg();
        prog[0] = 8'h15; prog[1] = 8'h30;
        step = 1'b0;
        push("st_fetch0", fe(4'd0));
        for (int k = 0; k < 10; k++) push($sformatf("st_stall%0d", k), fe(4'd0));
        start = 1'b1;
        runExpect(1'b0);
        step = 1'b1;
        push("st_exec_ldx", ex(4'd0, 2'b01, 3'b000, 2'b00, 1'b0));
        runExpect(1'b0);
        step = 1'b0;
        push("st_fetch1", fe(4'd1));
        push("st_stall1", fe(4'd1));
        push("st_stall1b", fe(4'd1));
        runExpect(1'b0);
        step = 1'b1;
        push("st_exec_sub", ex(4'd1, 2'b00, 3'b001, 2'b00, 1'b1));
        runExpect(1'b0);
        step = 1'b0;
        push("st_fetch2", fe(4'd2));
        runExpect(1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
